lfsr_chunk_feeder: RTL and testbench

Upstream sequencer for the dataSelectLFSR stage. It takes a packet of 64-bit words over a valid/ready handshake and seeds the LFSR once per packet through write/initialData. It then slices each word into ten 7-bit symbols and pushes them one per cycle through pushin/data. After the last symbol of the packet it captures the LFSR state (rnd1) as the packet signature and pulses result_valid.

---
 rtl/lfsr_chunk_feeder.sv | 117 +++++++++++
 tb/tb_lfsr_chunk_feeder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_chunk_feeder.sv
// lfsr_chunk_feeder
//   Upstream sequencer for the dataSelectLFSR stage. Seeds the LFSR once per
//   packet, slices each accepted 64-bit word into ten 7-bit symbols pushed one
//   per cycle, and captures the LFSR state as the packet signature after the
//   final symbol of the packet.
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   start, seed_sel, seed      packet start; seed select / external seed
//   abort                      drop the current packet, no result
//   din, din_valid, din_last   word stream in; din_ready accepts a word
//   write, initialData         LFSR seed load
//   pushin, data               LFSR symbol push
//   rnd1                       LFSR state
//   result, result_valid       packet signature, one-cycle pulse
//   word_count                 words accepted in the current/last packet (saturating)
//   busy                       high whenever not IDLE
module lfsr_chunk_feeder #(
  parameter logic [63:0] SEED_DEFAULT = 64'h184EB5240ADEFEBB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        seed_sel,
  input  logic [63:0] seed,
  input  logic        abort,
  input  logic [63:0] din,
  input  logic        din_valid,
  input  logic        din_last,
  output logic        din_ready,
  output logic        write,
  output logic [63:0] initialData,
  output logic        pushin,
  output logic [6:0]  data,
  input  logic [63:0] rnd1,
  output logic [63:0] result,
  output logic        result_valid,
  output logic [15:0] word_count,
  output logic        busy
);

  // Tied to the 7-bit LFSR data port: ceil(64/7).
  localparam int SYMS_PER_WORD = 10;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] SHIFT   = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;

  logic [2:0]  state;
  logic [63:0] buffer;
  logic [3:0]  cnt;
  logic        last_f;

  // Handshake/strobe outputs decode straight from the state register, so no
  // input reaches an output combinationally and reset clears them at once.
  assign write     = (state == LOAD);
  assign pushin    = (state == SHIFT);
  assign din_ready = (state == WAIT);
  assign busy      = (state != IDLE);
  assign data      = buffer[6:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      buffer       <= '0;
      cnt          <= '0;
      last_f       <= 1'b0;
      initialData  <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      word_count   <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            initialData <= seed_sel ? seed : SEED_DEFAULT;
            word_count  <= '0;
            state       <= LOAD;
          end
        end
        LOAD: state <= abort ? IDLE : WAIT;
        WAIT: begin
          if (abort) begin
            state <= IDLE;
          end else if (din_valid) begin
            buffer <= din;
            last_f <= din_last;
            cnt    <= '0;
            if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          // Zero fill leaves din[63] alone in bit 0 for the tenth symbol.
          buffer <= buffer >> 7;
          cnt    <= cnt + 4'd1;
          if (abort)
            state <= IDLE;
          else if (cnt == 4'(SYMS_PER_WORD - 1))
            state <= last_f ? CAPTURE : WAIT;
        end
        CAPTURE: begin
          // rnd1 already includes the final push made in the last SHIFT cycle.
          if (!abort) begin
            result       <= rnd1;
            result_valid <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_chunk_feeder.sv
module tb_lfsr_chunk_feeder;

  localparam logic [63:0] DEF_SEED = 64'h184EB5240ADEFEBB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, seed_sel = 1'b0, abort = 1'b0;
  logic [63:0] seed = '0, din = '0;
  logic        din_valid = 1'b0, din_last = 1'b0;
  logic        din_ready, write, pushin, result_valid, busy;
  logic [63:0] initialData, result, rnd1;
  logic [6:0]  data;
  logic [15:0] word_count;

  int n_checks = 0, n_fail = 0, n_push = 0, n_rv = 0;
  logic [6:0]  sym_q[$];
  logic [63:0] res_q[$];
  logic [63:0] mstate;            // expected LFSR state of the packet in flight
  logic [63:0] last_exp = '0;     // last signature the DUT should be holding
  logic [63:0] lf = '0;           // bench LFSR model

  lfsr_chunk_feeder dut (
    .clk(clk), .reset(reset), .start(start), .seed_sel(seed_sel), .seed(seed),
    .abort(abort), .din(din), .din_valid(din_valid), .din_last(din_last),
    .din_ready(din_ready), .write(write), .initialData(initialData),
    .pushin(pushin), .data(data), .rnd1(rnd1), .result(result),
    .result_valid(result_valid), .word_count(word_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream LFSR: load on write, mix one symbol per push.
  function automatic logic [63:0] lfsr_next(input logic [63:0] s, input logic [6:0] d);
    logic fb;
    fb = s[63] ^ s[62] ^ s[60] ^ s[59];
    return {s[62:0], fb} ^ {57'b0, d};
  endfunction

  always @(posedge clk) begin
    if (write) lf <= initialData;
    else if (pushin) lf <= lfsr_next(lf, data);
  end
  assign rnd1 = lf;

  // Scoreboard monitor: symbols and signatures popped as the DUT emits them.
  always @(negedge clk) begin
    if (!reset) begin
      if (write && pushin) begin
        n_checks++; n_fail++;
        $display("FAIL write_pushin_overlap: both high at %0t", $time);
      end
      if (pushin) begin
        logic [6:0] e;
        n_push++;
        n_checks++;
        if (sym_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_push: data=%02h with nothing expected", data);
        end else begin
          e = sym_q.pop_front();
          if (data !== e) begin
            n_fail++;
            $display("FAIL symbol: got %02h expected %02h", data, e);
          end
        end
      end
      if (result_valid) begin
        logic [63:0] r;
        n_rv++;
        n_checks++;
        if (res_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: result=%016h", result);
        end else begin
          r = res_q.pop_front();
          last_exp = r;
          if (result !== r) begin
            n_fail++;
            $display("FAIL signature: got %016h expected %016h", result, r);
          end
        end
      end
    end
  end

  task automatic start_pkt(input logic sel, input logic [63:0] s);
    @(negedge clk);
    start = 1'b1; seed_sel = sel; seed = s;
    mstate = sel ? s : DEF_SEED;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w, input logic last);
    int n = 0;
    while (!din_ready && n < 50) begin @(negedge clk); n++; end
    if (!din_ready) begin
      n_checks++; n_fail++;
      $display("FAIL din_ready_timeout: din_ready=%0b after %0d cycles", din_ready, n);
    end
    din = w; din_valid = 1'b1; din_last = last;
    for (int k = 0; k < 10; k++) begin
      logic [6:0] s;
      s = 7'((w >> (7 * k)) & 64'h7F);
      sym_q.push_back(s);
      mstate = lfsr_next(mstate, s);
    end
    if (last) res_q.push_back(mstate);
    @(negedge clk);
    din_valid = 1'b0; din_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    n_checks++;
    if (busy) begin
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b expected 0", busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({write, pushin, din_ready, result_valid, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %05b expected 00000",
               {write, pushin, din_ready, result_valid, busy});
    end
    n_checks++;
    if ({data, initialData, result, word_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: data=%02h init=%016h result=%016h wc=%0d expected all 0",
               data, initialData, result, word_count);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_seed();
    start_pkt(1'b1, 64'hFC0F38CA7DB868B5);
    n_checks++;
    if (write !== 1'b1 || initialData !== 64'hFC0F38CA7DB868B5) begin
      n_fail++;
      $display("FAIL seed_ext: write=%0b init=%016h expected 1 FC0F38CA7DB868B5", write, initialData);
    end
    @(negedge clk);
    n_checks++;
    if (write !== 1'b0 || din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL seed_write_pulse: write=%0b din_ready=%0b expected 0 1", write, din_ready);
    end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    start_pkt(1'b0, 64'h1234);
    n_checks++;
    if (write !== 1'b1 || initialData !== DEF_SEED) begin
      n_fail++;
      $display("FAIL seed_default: write=%0b init=%016h expected 1 %016h", write, initialData, DEF_SEED);
    end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    wait_idle();
  endtask

  task automatic test_slicing();
    start_pkt(1'b1, 64'hA5A5_0F0F_3C3C_9696);
    send_word(64'h8000000000000001, 1'b1);
    wait_idle();
    start_pkt(1'b0, '0);
    send_word(64'hFFFFFFFFFFFFFFFF, 1'b1);
    wait_idle();
  endtask

  task automatic test_signature();
    int n = 0;
    start_pkt(1'b1, 64'h0);
    send_word(64'h0, 1'b1);
    // Now in the cycle after acceptance; result_valid is due 11 cycles later.
    while (!result_valid && n < 40) begin @(negedge clk); n++; end
    n_checks++;
    if (n != 11 || result !== 64'h0) begin
      n_fail++;
      $display("FAIL zero_latency: cycles=%0d result=%016h expected 11 0", n, result);
    end
    wait_idle();
    start_pkt(1'b1, {$urandom, $urandom});
    n_push = 0;
    for (int i = 0; i < 3; i++) send_word({$urandom, $urandom}, i == 2);
    wait_idle();
    n_checks++;
    if (word_count !== 16'd3 || n_push != 30) begin
      n_fail++;
      $display("FAIL multiword: word_count=%0d pushes=%0d expected 3 30", word_count, n_push);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] s0;
    s0 = 64'h0123_4567_89AB_CDEF;
    start_pkt(1'b1, s0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (din_ready !== 1'b1 || pushin !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL backpressure: ready=%0b pushin=%0b busy=%0b expected 1 0 1", din_ready, pushin, busy);
      end
      @(negedge clk);
    end
    send_word(64'hDEAD_BEEF_CAFE_F00D, 1'b1);
    @(negedge clk);
    start = 1'b1; seed_sel = 1'b1; seed = 64'hFFFF;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (initialData !== s0 || pushin !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy: init=%016h pushin=%0b expected %016h 1", initialData, pushin, s0);
    end
    wait_idle();
  endtask

  task automatic test_abort();
    start_pkt(1'b0, '0);
    send_word({$urandom, $urandom}, 1'b1);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (pushin !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stop: pushin=%0b busy=%0b expected 0 0", pushin, busy);
    end
    sym_q.delete(); res_q.delete();
    n_rv = 0;
    repeat (15) @(negedge clk);
    n_checks++;
    if (n_rv != 0 || result !== last_exp) begin
      n_fail++;
      $display("FAIL abort_result: pulses=%0d result=%016h expected 0 %016h", n_rv, result, last_exp);
    end
  endtask

  task automatic test_reset_mid();
    start_pkt(1'b1, 64'h55AA);
    send_word(64'h1111_2222_3333_4444, 1'b1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({write, pushin, din_ready, result_valid, busy} !== 5'b0 ||
        {data, initialData, result, word_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: strobes=%05b data=%02h init=%016h result=%016h wc=%0d expected all 0",
               {write, pushin, din_ready, result_valid, busy}, data, initialData, result, word_count);
    end
    sym_q.delete(); res_q.delete();
    last_exp = '0;
    @(negedge clk); reset = 1'b0;
    n_push = 0; n_rv = 0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (n_push != 0 || n_rv != 0) begin
      n_fail++;
      $display("FAIL reset_release: pushes=%0d results=%0d expected 0 0", n_push, n_rv);
    end
  endtask

  initial begin
    test_reset();
    test_seed();
    test_slicing();
    test_signature();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    n_checks++;
    if (sym_q.size() != 0 || res_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: symbols=%0d results=%0d expected 0 0", sym_q.size(), res_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
